// File: rtl/ex_stage.sv
// Execute stage: ALU, jump resolution and registered EX/MEM outputs.
// Define EX_MUL_EN to build the iterative shift-add multiplier (op 11) and its IDLE/BUSY FSM.
module ex_stage #(
    parameter int PC_W     = 5,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_rd1,
    input  logic [31:0]     in_rd2,
    input  logic [31:0]     in_imm,
    input  logic            in_alu_src,
    input  logic [4:0]      in_alu_op,
    input  logic            in_is_jump,
    input  logic            in_reg_wrenable,
    input  logic [4:0]      in_write_reg,
    input  logic            in_mem_wrenable,
    input  logic            in_mem_to_reg,
    input  logic            in_flush,
    output logic            out_stall,
    output logic [31:0]     out_alu_result,
    output logic [31:0]     out_store_data,
    output logic [4:0]      out_write_reg,
    output logic            out_reg_wrenable,
    output logic            out_mem_wrenable,
    output logic            out_mem_to_reg,
    output logic            out_jump_taken,
    output logic [PC_W-1:0] out_jump_target
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;

    if (MUL_STEP < 1 || MUL_STEP > 32 || (32 % MUL_STEP) != 0) begin : g_bad_step
        $error("ex_stage: MUL_STEP must divide 32");
    end

    logic [31:0]     opb;
    logic [31:0]     alu_res;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_tgt;
    logic            mul_stall;
    logic            mul_done;
    logic [31:0]     mul_result;

    logic [31:0]     alu_result_q, alu_result_d;
    logic [31:0]     store_data_q, store_data_d;
    logic [4:0]      write_reg_q, write_reg_d;
    logic            reg_wrenable_q, reg_wrenable_d;
    logic            mem_wrenable_q, mem_wrenable_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic            jump_taken_q, jump_taken_d;
    logic [PC_W-1:0] jump_target_q, jump_target_d;

    always_comb begin
        opb      = in_alu_src ? in_imm : in_rd2;
        pc_inc   = in_pc + PC_W'(1);
        jump_tgt = in_pc + in_imm[PC_W-1:0];
        alu_res  = '0;
        case (in_alu_op)
            OP_ADD:   alu_res = in_rd1 + opb;
            OP_SUB:   alu_res = in_rd1 - opb;
            OP_AND:   alu_res = in_rd1 & opb;
            OP_OR:    alu_res = in_rd1 | opb;
            OP_XOR:   alu_res = in_rd1 ^ opb;
            OP_SLL:   alu_res = in_rd1 << opb[4:0];
            OP_SRL:   alu_res = in_rd1 >> opb[4:0];
            OP_SRA:   alu_res = $signed(in_rd1) >>> opb[4:0];
            OP_SLT:   alu_res = {31'b0, $signed(in_rd1) < $signed(opb)};
            OP_SLTU:  alu_res = {31'b0, in_rd1 < opb};
            OP_PASSB: alu_res = opb;
            default:  alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam int         N_STEPS = 32 / MUL_STEP;
    localparam logic [5:0] LAST    = 6'(N_STEPS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] partial;

    // A shifts left and B shifts right each step, so the low MUL_STEP bits of B
    // always select the current partial product.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mul_b_q[i]) partial = partial + (mul_a_q << i);
        end
        state_d   = state_q;
        count_d   = count_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        acc_d     = acc_q;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        if (in_flush) begin
            state_d = IDLE;
            count_d = '0;
        end else if (state_q == IDLE) begin
            if (in_alu_op == OP_MUL && !in_is_jump) begin
                mul_stall = 1'b1;
                state_d   = BUSY;
                count_d   = '0;
                mul_a_d   = in_rd1;
                mul_b_d   = opb;
                acc_d     = '0;
            end
        end else begin
            acc_d   = acc_q + partial;
            mul_a_d = mul_a_q << MUL_STEP;
            mul_b_d = mul_b_q >> MUL_STEP;
            if (count_q == LAST) begin
                mul_done = 1'b1;
                state_d  = IDLE;
                count_d  = '0;
            end else begin
                mul_stall = 1'b1;
                count_d   = count_q + 6'd1;
            end
        end
        mul_result = acc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign mul_stall  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    // Stall cycles and flushes emit a bubble; data fields are don't-care then.
    always_comb begin
        if (mul_done)        alu_result_d = mul_result;
        else if (in_is_jump) alu_result_d = {{(32-PC_W){1'b0}}, pc_inc};
        else                 alu_result_d = alu_res;
        store_data_d  = in_rd2;
        write_reg_d   = in_write_reg;
        jump_target_d = jump_tgt;
        if (in_flush || mul_stall) begin
            reg_wrenable_d = 1'b0;
            mem_wrenable_d = 1'b0;
            mem_to_reg_d   = 1'b0;
            jump_taken_d   = 1'b0;
        end else begin
            reg_wrenable_d = in_reg_wrenable;
            mem_wrenable_d = in_mem_wrenable;
            mem_to_reg_d   = in_mem_to_reg;
            jump_taken_d   = in_is_jump;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q   <= '0;
            store_data_q   <= '0;
            write_reg_q    <= '0;
            reg_wrenable_q <= 1'b0;
            mem_wrenable_q <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            jump_taken_q   <= 1'b0;
            jump_target_q  <= '0;
        end else begin
            alu_result_q   <= alu_result_d;
            store_data_q   <= store_data_d;
            write_reg_q    <= write_reg_d;
            reg_wrenable_q <= reg_wrenable_d;
            mem_wrenable_q <= mem_wrenable_d;
            mem_to_reg_q   <= mem_to_reg_d;
            jump_taken_q   <= jump_taken_d;
            jump_target_q  <= jump_target_d;
        end
    end

    assign out_stall        = mul_stall;
    assign out_alu_result   = alu_result_q;
    assign out_store_data   = store_data_q;
    assign out_write_reg    = write_reg_q;
    assign out_reg_wrenable = reg_wrenable_q;
    assign out_mem_wrenable = mem_wrenable_q;
    assign out_mem_to_reg   = mem_to_reg_q;
    assign out_jump_taken   = jump_taken_q;
    assign out_jump_target  = jump_target_q;

endmodule
